// File: rtl/bist_dff_bank.sv
// WIDTH-bit BIST register bank: hold, parallel load, scan shift and Galois LFSR step with lock-up recovery.
// Optional build macro BIST_DFF_BANK_MISR_EN turns the LFSR step into a MISR that folds d into the state.
module bist_dff_bank #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'hFFFF_FFFF,
  parameter logic [31:0] POLY      = 32'h0000_001D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             scan_in,
  output logic [WIDTH-1:0] q,
  output logic             scan_out,
  output logic             lockup
);

  // Both parameters are taken modulo 2**WIDTH; unused upper bits are simply dropped.
  localparam logic [WIDTH-1:0] RST_V  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] POLY_V = POLY[WIDTH-1:0];

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_LFSR  = 2'b11
  } mode_e;

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("bist_dff_bank: WIDTH must be in 2..32");
    end
    if (POLY[0] == 1'b0) begin : g_bad_poly
      $error("bist_dff_bank: POLY bit 0 must be 1");
    end
  endgenerate

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] step_v;
  mode_e            mode_v;

  always_comb begin
    mode_v = mode_e'(mode);
    step_v = {q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? POLY_V : '0);
  end

`ifdef BIST_DFF_BANK_MISR_EN

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode_v)
        MODE_LOAD:  q_d = d;
        MODE_SHIFT: q_d = {q_q[WIDTH-2:0], scan_in};
        MODE_LFSR:  q_d = step_v ^ d;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= RST_V;
    end else begin
      q_q <= q_d;
    end
  end

  // All-zero is a legal MISR state, so there is nothing to detect.
  assign lockup = 1'b0;

`else

  logic lockup_q, lockup_d;

  always_comb begin
    q_d      = q_q;
    lockup_d = lockup_q;
    if (en) begin
      case (mode_v)
        MODE_LOAD: begin
          q_d      = d;
          lockup_d = 1'b0;
        end
        MODE_SHIFT: q_d = {q_q[WIDTH-2:0], scan_in};
        MODE_LFSR: begin
          // Zero is a fixed point of the LFSR: reseed instead of stepping.
          if (q_q == '0) begin
            q_d      = RST_V;
            lockup_d = 1'b1;
          end else begin
            q_d = step_v;
          end
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q      <= RST_V;
      lockup_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      lockup_q <= lockup_d;
    end
  end

  assign lockup = lockup_q;

`endif

  assign q        = q_q;
  assign scan_out = q_q[WIDTH-1];

endmodule
